// File: rtl/crossbar_pipe.sv
// crossbar_pipe: registered N-to-M lane crossbar; each output lane picks one input lane via a handshaked select register.
// Latency: accept at edge k -> dn_vld/dn_dat from cycle k+1 when empty; 1 beat/clk sustained while dn_rdy=1.
// Backpressure: 2-entry skid (M + S); up_rdy drops only when both hold beats. Option macro: CROSSBAR_PIPE_OOB_ZERO_EN.
module crossbar_pipe #(
    parameter int data_width = 16,
    parameter int num_input  = 8,
    parameter int num_output = 8,
    parameter int sel_width  = $clog2(num_input)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             up_vld,
    output logic                             up_rdy,
    input  logic [num_input*data_width-1:0]  up_dat,
    input  logic                             cfg_vld,
    output logic                             cfg_rdy,
    input  logic [num_output*sel_width-1:0]  cfg_sel,
    output logic                             cfg_err,
    output logic                             dn_vld,
    input  logic                             dn_rdy,
    output logic [num_output*data_width-1:0] dn_dat,
    output logic [1:0]                       occ
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [num_output*sel_width-1:0] ident_sel();
        logic [num_output*sel_width-1:0] v;
        v = '0;
        for (int j = 0; j < num_output; j++) begin
            v[j*sel_width +: sel_width] = sel_width'(j % num_input);
        end
        return v;
    endfunction

    localparam logic [num_output*sel_width-1:0] IDENT_SEL = ident_sel();

    // Out-of-range fields fall through the lane match and keep the default value.
    function automatic logic [num_output*data_width-1:0] route(
        input logic [num_input*data_width-1:0] dat,
        input logic [num_output*sel_width-1:0] sel
    );
        logic [num_output*data_width-1:0] r;
        logic [sel_width-1:0]             f;
        r = '0;
        for (int j = 0; j < num_output; j++) begin
            f = sel[j*sel_width +: sel_width];
`ifdef CROSSBAR_PIPE_OOB_ZERO_EN
            r[j*data_width +: data_width] = '0;
`else
            r[j*data_width +: data_width] = dat[(num_input-1)*data_width +: data_width];
`endif
            for (int i = 0; i < num_input; i++) begin
                if (f == sel_width'(i)) begin
                    r[j*data_width +: data_width] = dat[i*data_width +: data_width];
                end
            end
        end
        return r;
    endfunction

    state_t                           state_q, state_d;
    logic [num_output*data_width-1:0] m_q, m_d;
    logic [num_output*data_width-1:0] s_q, s_d;
    logic [num_output*sel_width-1:0]  sel_q;
    logic [num_output*data_width-1:0] routed;
    logic                             acc;
    logic                             pop;

    assign routed  = route(up_dat, sel_q);
    assign up_rdy  = (state_q != ST_FULL);
    assign dn_vld  = (state_q != ST_EMPTY);
    assign occ     = state_q;
    assign dn_dat  = m_q;
    assign cfg_rdy = 1'b1;
    assign acc     = up_vld & up_rdy;
    assign pop     = dn_vld & dn_rdy;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d = ST_ONE;
                    m_d     = routed;
                end
            end
            ST_ONE: begin
                if (acc && !pop) begin
                    state_d = ST_FULL;
                    s_d     = routed;
                end else if (acc && pop) begin
                    m_d = routed;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_ONE;
                    m_d     = s_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            sel_q   <= IDENT_SEL;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            if (cfg_vld) begin
                sel_q <= cfg_sel;
            end
        end
    end

`ifdef CROSSBAR_PIPE_OOB_ZERO_EN
    function automatic logic any_oob(input logic [num_output*sel_width-1:0] sel);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < num_output; j++) begin
            if (int'(sel[j*sel_width +: sel_width]) >= num_input) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (cfg_vld && any_oob(cfg_sel)) begin
            err_q <= 1'b1;
        end
    end

    assign cfg_err = err_q;
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_crossbar_pipe.sv
// Bench for crossbar_pipe: routing table, hand sequences for skid/config/reset corners, random run against a queue model.
`timescale 1ns/1ps
module tb_crossbar_pipe;
    localparam int DW  = 16;
    localparam int NI  = 8;
    localparam int NO  = 8;
    localparam int SW  = 3;
    localparam int NI6 = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             up_vld, up_rdy, cfg_vld, cfg_rdy, cfg_err, dn_vld, dn_rdy;
    logic [NI*DW-1:0] up_dat;
    logic [NO*SW-1:0] cfg_sel;
    logic [NO*DW-1:0] dn_dat;
    logic [1:0]       occ;

    crossbar_pipe #(.data_width(DW), .num_input(NI), .num_output(NO), .sel_width(SW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .up_vld(up_vld), .up_rdy(up_rdy), .up_dat(up_dat),
        .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_sel(cfg_sel), .cfg_err(cfg_err),
        .dn_vld(dn_vld), .dn_rdy(dn_rdy), .dn_dat(dn_dat), .occ(occ)
    );

    logic              b_up_vld, b_up_rdy, b_cfg_vld, b_cfg_rdy, b_cfg_err, b_dn_vld, b_dn_rdy;
    logic [NI6*DW-1:0] b_up_dat;
    logic [NO*SW-1:0]  b_cfg_sel;
    logic [NO*DW-1:0]  b_dn_dat;
    logic [1:0]        b_occ;

    crossbar_pipe #(.data_width(DW), .num_input(NI6), .num_output(NO), .sel_width(SW)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .up_vld(b_up_vld), .up_rdy(b_up_rdy), .up_dat(b_up_dat),
        .cfg_vld(b_cfg_vld), .cfg_rdy(b_cfg_rdy), .cfg_sel(b_cfg_sel), .cfg_err(b_cfg_err),
        .dn_vld(b_dn_vld), .dn_rdy(b_dn_rdy), .dn_dat(b_dn_dat), .occ(b_occ)
    );

    int total = 0;
    int bad   = 0;

    // Routing table: select field per output lane, expected output lane for input lanes 0x1000+i.
    int tsel [5][NO] = '{
        '{0, 1, 2, 3, 4, 5, 6, 7},
        '{7, 6, 5, 4, 3, 2, 1, 0},
        '{3, 3, 3, 3, 3, 3, 3, 3},
        '{1, 2, 3, 4, 5, 6, 7, 0},
        '{5, 5, 0, 2, 7, 1, 1, 6}
    };
    int texp [5][NO] = '{
        '{'h1000, 'h1001, 'h1002, 'h1003, 'h1004, 'h1005, 'h1006, 'h1007},
        '{'h1007, 'h1006, 'h1005, 'h1004, 'h1003, 'h1002, 'h1001, 'h1000},
        '{'h1003, 'h1003, 'h1003, 'h1003, 'h1003, 'h1003, 'h1003, 'h1003},
        '{'h1001, 'h1002, 'h1003, 'h1004, 'h1005, 'h1006, 'h1007, 'h1000},
        '{'h1005, 'h1005, 'h1000, 'h1002, 'h1007, 'h1001, 'h1001, 'h1006}
    };

    // Reference: up to two beats in flight, each routed with the select active when accepted.
    logic [NO*DW-1:0] mq[$];
    logic [NO*DW-1:0] m_last;
    int               msel[NO];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NI*DW-1:0] lanes(input int base);
        logic [NI*DW-1:0] v;
        for (int i = 0; i < NI; i++) v[i*DW +: DW] = DW'(base + i);
        return v;
    endfunction

    function automatic logic [NO*SW-1:0] pack_sel(input int s[NO]);
        logic [NO*SW-1:0] v;
        for (int j = 0; j < NO; j++) v[j*SW +: SW] = SW'(s[j]);
        return v;
    endfunction

    function automatic logic [NO*DW-1:0] model_route(input logic [NI*DW-1:0] d);
        logic [NO*DW-1:0] r;
        for (int j = 0; j < NO; j++) r[j*DW +: DW] = d[msel[j]*DW +: DW];
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last = '0;
        for (int j = 0; j < NO; j++) msel[j] = j;
    endtask

    task automatic cycle(output bit acc_o);
        bit               acc, pop;
        logic [NO*DW-1:0] beat;
        acc  = up_vld && (mq.size() < 2);
        pop  = (mq.size() > 0) && dn_rdy;
        beat = model_route(up_dat);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(beat);
        if (mq.size() > 0) m_last = mq[0];
        if (cfg_vld) for (int j = 0; j < NO; j++) msel[j] = int'(cfg_sel[j*SW +: SW]);
        #1;
        check("dn_vld", dn_vld, mq.size() != 0);
        check("occ", occ, mq.size());
        check("up_rdy", up_rdy, mq.size() < 2);
        check("dn_dat", dn_dat, m_last);
        acc_o = acc;
    endtask

    initial begin
        bit               a;
        int               idx;
        int               rev[NO];
        int               s6[NO];
        logic [NO*DW-1:0] exp_v;

        rst_n   = 1'b0;
        up_vld  = 1'b0; up_dat = '0; cfg_vld = 1'b0; cfg_sel = '0; dn_rdy = 1'b0;
        b_up_vld = 1'b0; b_up_dat = '0; b_cfg_vld = 1'b0; b_cfg_sel = '0; b_dn_rdy = 1'b0;
        model_reset();
        for (int j = 0; j < NO; j++) rev[j] = NO - 1 - j;

        #3;
        check("rst_dn_vld", dn_vld, 0);
        check("rst_occ", occ, 0);
        check("rst_up_rdy", up_rdy, 1);
        check("rst_cfg_rdy", cfg_rdy, 1);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_dn_dat", dn_dat, 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // identity after reset, no config load
        up_dat = lanes('h1000); up_vld = 1'b1; dn_rdy = 1'b1;
        cycle(a);
        check("ident_dat", dn_dat, lanes('h1000));
        up_vld = 1'b0;
        cycle(a);
        check("ident_drain_occ", occ, 0);

        for (int t = 0; t < 5; t++) begin
            cfg_sel = pack_sel(tsel[t]); cfg_vld = 1'b1;
            cycle(a);
            cfg_vld = 1'b0; up_dat = lanes('h1000); up_vld = 1'b1;
            cycle(a);
            up_vld = 1'b0;
            for (int j = 0; j < NO; j++) exp_v[j*DW +: DW] = DW'(texp[t][j]);
            check("table_dat", dn_dat, exp_v);
            cycle(a);
        end

        // reversed select, 16-beat stream
        cfg_sel = pack_sel(rev); cfg_vld = 1'b1;
        cycle(a);
        cfg_vld = 1'b0;
        for (int n = 0; n < 16; n++) begin
            up_dat = lanes('h3000 + n*16); up_vld = 1'b1;
            cycle(a);
            check("stream_acc", a, 1);
        end
        up_vld = 1'b0;
        cycle(a); cycle(a);

        // backpressure: A, B stored, C held off
        dn_rdy = 1'b0; idx = 0; up_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            up_dat = lanes('h4000 + idx*'h100);
            cycle(a);
            if (a) idx++;
        end
        for (int j = 0; j < NO; j++) exp_v[j*DW +: DW] = DW'('h4000 + NO - 1 - j);
        check("bp_accepted", idx, 2);
        check("bp_occ", occ, 2);
        check("bp_up_rdy", up_rdy, 0);
        check("bp_dat_A", dn_dat, exp_v);
        dn_rdy = 1'b1;
        for (int k = 0; k < 6 && idx < 3; k++) begin
            up_dat = lanes('h4000 + idx*'h100);
            cycle(a);
            if (a) idx++;
        end
        check("bp_C_accepted", idx, 3);
        up_vld = 1'b0;
        for (int k = 0; k < 3; k++) cycle(a);

        // config load in the same cycle as beat X; Y next cycle
        for (int j = 0; j < NO; j++) s6[j] = j;
        cfg_sel = pack_sel(s6); cfg_vld = 1'b1; up_dat = lanes('h5000); up_vld = 1'b1;
        cycle(a);
        for (int j = 0; j < NO; j++) exp_v[j*DW +: DW] = DW'('h5000 + NO - 1 - j);
        check("cfg_same_cycle_old", dn_dat, exp_v);
        cfg_vld = 1'b0; up_dat = lanes('h5100);
        cycle(a);
        check("cfg_next_cycle_new", dn_dat, lanes('h5100));
        up_vld = 1'b0;
        cycle(a);

        // async reset with occ=2 and a non-identity select
        dn_rdy = 1'b0; up_vld = 1'b1; up_dat = lanes('h6000);
        cfg_sel = pack_sel(rev); cfg_vld = 1'b1;
        cycle(a);
        cfg_vld = 1'b0;
        cycle(a);
        check("pre_rst_occ", occ, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dn_vld", dn_vld, 0);
        check("arst_occ", occ, 0);
        check("arst_up_rdy", up_rdy, 1);
        check("arst_dn_dat", dn_dat, 0);
        #2 rst_n = 1'b1;
        model_reset();
        up_dat = lanes('h6100); dn_rdy = 1'b1;
        cycle(a);
        check("arst_ident", dn_dat, lanes('h6100));
        up_vld = 1'b0;
        cycle(a);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            up_vld  = ($urandom_range(0, 3) != 0);
            dn_rdy  = ($urandom_range(0, 3) != 0);
            cfg_vld = ($urandom_range(0, 9) == 0);
            cfg_sel = SW*NO'($urandom);
            up_dat  = {$urandom, $urandom, $urandom, $urandom};
            cycle(a);
        end
        up_vld = 1'b0; cfg_vld = 1'b0;

        // 6-lane instance, field 3 out of range
        for (int j = 0; j < NO; j++) s6[j] = j % NI6;
        s6[3] = 7;
        b_cfg_sel = pack_sel(s6); b_cfg_vld = 1'b1;
        @(posedge clk); #1;
        b_cfg_vld = 1'b0;
        check("b_cfg_rdy", b_cfg_rdy, 1);
`ifdef CROSSBAR_PIPE_OOB_ZERO_EN
        check("b_cfg_err_set", b_cfg_err, 1);
`else
        check("b_cfg_err_tied", b_cfg_err, 0);
`endif
        for (int i = 0; i < NI6; i++) b_up_dat[i*DW +: DW] = DW'('h2000 + i);
        b_up_vld = 1'b1; b_dn_rdy = 1'b1;
        check("b_up_rdy", b_up_rdy, 1);
        @(posedge clk); #1;
        b_up_vld = 1'b0;
        check("b_dn_vld", b_dn_vld, 1);
        check("b_occ", b_occ, 1);
        check("b_lane0", b_dn_dat[0*DW +: DW], 'h2000);
        check("b_lane7", b_dn_dat[7*DW +: DW], 'h2001);
`ifdef CROSSBAR_PIPE_OOB_ZERO_EN
        check("b_lane3_zero", b_dn_dat[3*DW +: DW], 'h0000);
`else
        check("b_lane3_clamp", b_dn_dat[3*DW +: DW], 'h2005);
`endif
        @(posedge clk); #1;
`ifdef CROSSBAR_PIPE_OOB_ZERO_EN
        check("b_cfg_err_sticky", b_cfg_err, 1);
`else
        check("b_cfg_err_stays0", b_cfg_err, 0);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("b_rst_cfg_err", b_cfg_err, 0);
        check("b_rst_occ", b_occ, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
